ulpb_node_rx: RTL



---
 rtl/ulpb_node_rx_pkg.sv | 19 +
 rtl/ulpb_node_rx_if.sv | 24 ++
 rtl/ulpb_sync2.sv | 24 ++
 rtl/ulpb_node_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ulpb_node_rx_pkg.sv
// Shared definitions for the ULPB node receive front end: FSM states,
// field widths and the control-bit field width.
package ulpb_node_rx_pkg;

  localparam int BYTE_W     = 8;
  localparam int DATA_CNT_W = 3;
  localparam int CTRL_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_CTRL0     = 3'd4,
    ST_CTRL1     = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_e;

endpackage

// File: rtl/ulpb_node_rx_if.sv
// Receive-side result bundle from the ULPB node front end to its consumer.
interface ulpb_node_rx_if;
  import ulpb_node_rx_pkg::*;

  logic [BYTE_W-1:0]     RX_DATA;
  logic                  RX_VALID;
  logic                  RX_ADDR_MATCH;
  logic                  RX_ARB_BIT;
  logic                  RX_END;
  logic [CTRL_W-1:0]     RX_CTRL;
  logic [DATA_CNT_W-1:0] RX_PARTIAL;
  logic                  RX_BUSY;

  modport master (
    output RX_DATA, RX_VALID, RX_ADDR_MATCH, RX_ARB_BIT,
           RX_END, RX_CTRL, RX_PARTIAL, RX_BUSY
  );

  modport slave (
    input  RX_DATA, RX_VALID, RX_ADDR_MATCH, RX_ARB_BIT,
           RX_END, RX_CTRL, RX_PARTIAL, RX_BUSY
  );

endinterface

// File: rtl/ulpb_sync2.sv
// Two-flop synchroniser for a single asynchronous ring line; the reset
// value lets each line come out of reset at its idle bus level.
module ulpb_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/ulpb_node_rx.sv
// ULPB ring member-node receiver: oversamples ring clock/data, decodes
// arbitration, address, data and the escape-terminated control bits.
module ulpb_node_rx
  import ulpb_node_rx_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BROADCAST_ADDR = '1,
  parameter int                    IDLE_CYCLES    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUS_CLK_IN,
  input  logic                  BUS_DIN,
  input  logic [ADDR_WIDTH-1:0] NODE_ADDR,
  ulpb_node_rx_if.master        rx
);

  localparam int CNT_W  = ($clog2(ADDR_WIDTH) > DATA_CNT_W) ? $clog2(ADDR_WIDTH) : DATA_CNT_W;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  logic sclk_p1, sdin_p1, pclk_p2, pdin_p2;
  logic rise, oop, start;

  state_e                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [BYTE_W-1:0]     byte_q, byte_n;
  logic [IDLE_W-1:0]     idle_q, idle_n;
  logic                  c0_q, c0_n;
  logic [BYTE_W-1:0]     data_q, data_n;
  logic                  vld_q, vld_n;
  logic                  match_q, match_n;
  logic                  arb_q, arb_n;
  logic                  end_q, end_n;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_n;
  logic [DATA_CNT_W-1:0] part_q, part_n;

  ulpb_sync2 #(.RST_VAL(1'b1)) u_sync_clk (.CLK(CLK), .RESET(RESET), .d(BUS_CLK_IN), .q(sclk_p1));
  ulpb_sync2 #(.RST_VAL(1'b1)) u_sync_din (.CLK(CLK), .RESET(RESET), .d(BUS_DIN),    .q(sdin_p1));

  // Edge detection on synchronised lines; start is a data fall with the clock held high.
  assign rise  = sclk_p1 & ~pclk_p2;
  assign oop   = sclk_p1 & pclk_p2 & (sdin_p1 ^ pdin_p2);
  assign start = sclk_p1 & pclk_p2 & pdin_p2 & ~sdin_p1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pclk_p2 <= 1'b1;
      pdin_p2 <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      idle_q  <= '0;
      c0_q    <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      match_q <= 1'b0;
      arb_q   <= 1'b0;
      end_q   <= 1'b0;
      ctrl_q  <= '0;
      part_q  <= '0;
    end else begin
      pclk_p2 <= sclk_p1;
      pdin_p2 <= sdin_p1;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      byte_q  <= byte_n;
      idle_q  <= idle_n;
      c0_q    <= c0_n;
      data_q  <= data_n;
      vld_q   <= vld_n;
      match_q <= match_n;
      arb_q   <= arb_n;
      end_q   <= end_n;
      ctrl_q  <= ctrl_n;
      part_q  <= part_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    byte_n  = byte_q;
    idle_n  = idle_q;
    c0_n    = c0_q;
    data_n  = data_q;
    vld_n   = 1'b0;
    match_n = match_q;
    arb_n   = arb_q;
    end_n   = 1'b0;
    ctrl_n  = ctrl_q;
    part_n  = part_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_n = ST_ARB;
        cnt_n   = '0;
        byte_n  = '0;
        match_n = 1'b0;
      end
      ST_ARB: if (rise) begin
        arb_n   = sdin_p1;
        state_n = ST_ADDR;
      end
      ST_ADDR: begin
        if (rise) begin
          addr_n = {addr_q[ADDR_WIDTH-2:0], sdin_p1};
          if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            match_n = (addr_n == NODE_ADDR) || (addr_n == BROADCAST_ADDR);
            cnt_n   = '0;
            state_n = ST_DATA;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end else if (oop) begin
          part_n  = '0;
          state_n = ST_CTRL0;
        end
      end
      ST_DATA: begin
        if (rise) begin
          byte_n = {byte_q[BYTE_W-2:0], sdin_p1};
          if (cnt_q[DATA_CNT_W-1:0] == 3'd7) begin
            cnt_n = '0;
            if (match_q) begin
              data_n = byte_n;
              vld_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end else if (oop) begin
          // Escape mid-byte: report how many bits were dropped, never the byte.
          part_n  = cnt_q[DATA_CNT_W-1:0];
          state_n = ST_CTRL0;
        end
      end
      ST_CTRL0: if (rise) begin
        c0_n    = sdin_p1;
        state_n = ST_CTRL1;
      end
      ST_CTRL1: if (rise) begin
        ctrl_n  = {c0_q, sdin_p1};
        end_n   = 1'b1;
        idle_n  = '0;
        state_n = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (sclk_p1 & sdin_p1) begin
          if (idle_q == IDLE_W'(IDLE_CYCLES - 1)) begin
            state_n = ST_IDLE;
            match_n = 1'b0;
            idle_n  = '0;
          end else begin
            idle_n = idle_q + 1'b1;
          end
        end else begin
          idle_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rx.RX_DATA       = data_q;
  assign rx.RX_VALID      = vld_q;
  assign rx.RX_ADDR_MATCH = match_q;
  assign rx.RX_ARB_BIT    = arb_q;
  assign rx.RX_END        = end_q;
  assign rx.RX_CTRL       = ctrl_q;
  assign rx.RX_PARTIAL    = part_q;
  assign rx.RX_BUSY       = (state_q != ST_IDLE);

endmodule
